// File: rtl/fp_round_pkg.sv
// Shared types and default widths for the FP rounding datapath.
package fp_round_pkg;

  // Rounding modes as encoded on the rm inputs.
  typedef enum logic [1:0] {
    RM_RNE = 2'd0,  // round to nearest, ties to even
    RM_RTZ = 2'd1,  // round toward zero
    RM_RUP = 2'd2,  // round toward +inf
    RM_RDN = 2'd3   // round toward -inf
  } rm_e;

  // Default (binary32) widths.
  localparam int EXP_W_DEF  = 8;
  localparam int FRAC_W_DEF = 23;
  localparam int GRS_W_DEF  = 3;

  // {hidden, fraction, GRS} and {sign, exp, frac} widths for the defaults.
  localparam int MAN_W = 1 + FRAC_W_DEF + GRS_W_DEF;
  localparam int RES_W = 1 + EXP_W_DEF + FRAC_W_DEF;

  // Exponent codes for the default width: inf/NaN and largest finite.
  localparam logic [EXP_W_DEF-1:0] EXP_MAX    = '1;
  localparam logic [EXP_W_DEF-1:0] EXP_MAXFIN = EXP_MAX - 1'b1;

endpackage

// File: rtl/fp_round_pipe_if.sv
// Valid/ready bus of the rounding unit: normaliser-side input beat and
// result-register-side output beat.
interface fp_round_pipe_if
  import fp_round_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int GRS_W  = GRS_W_DEF
);

  logic                        in_valid;
  logic                        in_ready;
  logic                        in_sign;
  logic [EXP_W-1:0]            in_exp;
  logic [FRAC_W+GRS_W:0]       in_man;
  logic [1:0]                  in_rm;

  logic                        out_valid;
  logic                        out_ready;
  logic [EXP_W+FRAC_W:0]       out_result;
  logic                        out_inexact;
  logic                        out_overflow;

  // Driver side: produces input beats, consumes results.
  modport master (
    output in_valid, in_sign, in_exp, in_man, in_rm, out_ready,
    input  in_ready, out_valid, out_result, out_inexact, out_overflow
  );

  // Rounding unit side.
  modport slave (
    input  in_valid, in_sign, in_exp, in_man, in_rm, out_ready,
    output in_ready, out_valid, out_result, out_inexact, out_overflow
  );

endinterface

// File: rtl/fp_round_decide.sv
// Combinational rounding decision: looks at the LSB and the bits below it
// and decides whether to increment and whether any precision is lost.
// Kept free of pipeline state so the multiplier can reuse it.
module fp_round_decide
  import fp_round_pkg::*;
#(
  parameter int GRS_W = GRS_W_DEF
) (
  input  logic [GRS_W:0] low_bits,  // {lsb, guard, round..sticky}
  input  logic           sign,
  input  rm_e            rm,
  output logic           round_up,
  output logic           inexact
);

  logic lsb;
  logic guard;
  logic sticky;

  // Decide increment from guard/sticky/lsb and the rounding direction.
  // NOTE: every output is assigned on every path (default arm included), so
  // this stays pure combinational logic and no latch is inferred.
  always_comb begin
    lsb     = low_bits[GRS_W];
    guard   = low_bits[GRS_W-1];
    sticky  = |low_bits[GRS_W-2:0];
    inexact = guard | sticky;
    case (rm)
      RM_RNE:  round_up = guard & (sticky | lsb);
      RM_RTZ:  round_up = 1'b0;
      RM_RUP:  round_up = ~sign & inexact;
      RM_RDN:  round_up = sign & inexact;
      default: round_up = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined IEEE-754 rounding unit.
// Stage 1 decides and applies the increment; stage 2 renormalises on
// carry-out and resolves overflow to infinity or max-finite by mode.
// Optional feature: define FP_ROUND_STICKY_FLAGS_EN to add flags_clr and an
// accumulating sticky_flags {overflow, inexact} register.
module fp_round_pipe
  import fp_round_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int GRS_W  = GRS_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_round_pipe_if.slave       bus
`ifdef FP_ROUND_STICKY_FLAGS_EN
  ,
  input  logic                 flags_clr,
  output logic [1:0]           sticky_flags
`endif
);

  localparam int MAN_BITS = 1 + FRAC_W + GRS_W;
  localparam int RES_BITS = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_FIN  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

  // Stage 1 registers.
  logic              s1_valid_q,   s1_valid_d;
  logic              s1_sign_q,    s1_sign_d;
  logic [EXP_W-1:0]  s1_exp_q,     s1_exp_d;
  logic [FRAC_W:0]   s1_sum_q,     s1_sum_d;
  logic              s1_carry_q,   s1_carry_d;
  logic              s1_inexact_q, s1_inexact_d;
  rm_e               s1_rm_q,      s1_rm_d;
  logic              s1_sub_up_q,  s1_sub_up_d;

  // Stage 2 (output) registers.
  logic                out_valid_q,    out_valid_d;
  logic [RES_BITS-1:0] out_result_q,   out_result_d;
  logic                out_inexact_q,  out_inexact_d;
  logic                out_overflow_q, out_overflow_d;

  logic              s2_advance;
  logic              s1_accept;
  logic              in_special;
  logic              dec_round_up;
  logic              dec_inexact;
  logic              round_up;
  logic [FRAC_W+1:0] inc;
  rm_e               in_rm;

  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  exp_r;
  logic [FRAC_W-1:0] frac_r;
  logic              ovf;
  logic              to_inf;

  assign in_rm = rm_e'(bus.in_rm);

  fp_round_decide #(.GRS_W(GRS_W)) u_decide (
    .low_bits (bus.in_man[GRS_W:0]),
    .sign     (bus.in_sign),
    .rm       (in_rm),
    .round_up (dec_round_up),
    .inexact  (dec_inexact)
  );

  // Handshake and stage-1 next state: apply the increment to the mantissa.
  always_comb begin
    s2_advance = ~out_valid_q | bus.out_ready;
    s1_accept  = ~s1_valid_q | s2_advance;

    // inf/NaN inputs pass through untouched and never raise flags.
    in_special = (bus.in_exp == EXP_ONES);
    round_up   = dec_round_up & ~in_special;
    inc        = {1'b0, bus.in_man[MAN_BITS-1:GRS_W]} + (FRAC_W+2)'(round_up);

    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_sum_d     = s1_sum_q;
    s1_carry_d   = s1_carry_q;
    s1_inexact_d = s1_inexact_q;
    s1_rm_d      = s1_rm_q;
    s1_sub_up_d  = s1_sub_up_q;

    if (s1_accept) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_d    = bus.in_sign;
        s1_exp_d     = bus.in_exp;
        s1_sum_d     = inc[FRAC_W:0];
        s1_carry_d   = inc[FRAC_W+1];
        s1_inexact_d = dec_inexact & ~in_special;
        s1_rm_d      = in_rm;
        // Subnormal rounded up into the hidden bit becomes the smallest normal.
        s1_sub_up_d  = (bus.in_exp == '0) & ~bus.in_man[MAN_BITS-1] & inc[FRAC_W];
      end
    end
  end

  // Stage-2 next state: renormalise on carry, then resolve overflow by mode.
  always_comb begin
    exp_inc = s1_exp_q + EXP_ONE;
    if (s1_carry_q) begin
      frac_r = s1_sum_q[FRAC_W:1];
      exp_r  = exp_inc;
    end else begin
      frac_r = s1_sum_q[FRAC_W-1:0];
      exp_r  = s1_sub_up_q ? EXP_ONE : s1_exp_q;
    end

    ovf    = s1_carry_q & (exp_inc == EXP_ONES);
    to_inf = (s1_rm_q == RM_RNE) |
             ((s1_rm_q == RM_RUP) & ~s1_sign_q) |
             ((s1_rm_q == RM_RDN) &  s1_sign_q);
    if (ovf) begin
      if (to_inf) begin
        exp_r  = EXP_ONES;
        frac_r = '0;
      end else begin
        exp_r  = EXP_FIN;
        frac_r = '1;
      end
    end

    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_inexact_d  = out_inexact_q;
    out_overflow_d = out_overflow_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d   = {s1_sign_q, exp_r, frac_r};
        out_inexact_d  = s1_inexact_q | ovf;
        out_overflow_d = ovf;
      end
    end
  end

  // Pipeline state registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: data flops are reset alongside the valids so the outputs read 0
  // coming out of reset, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_exp_q       <= '0;
      s1_sum_q       <= '0;
      s1_carry_q     <= 1'b0;
      s1_inexact_q   <= 1'b0;
      s1_rm_q        <= RM_RNE;
      s1_sub_up_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_inexact_q  <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_sign_q      <= s1_sign_d;
      s1_exp_q       <= s1_exp_d;
      s1_sum_q       <= s1_sum_d;
      s1_carry_q     <= s1_carry_d;
      s1_inexact_q   <= s1_inexact_d;
      s1_rm_q        <= s1_rm_d;
      s1_sub_up_q    <= s1_sub_up_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_inexact_q  <= out_inexact_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign bus.in_ready     = s1_accept;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_inexact  = out_inexact_q;
  assign bus.out_overflow = out_overflow_q;

`ifdef FP_ROUND_STICKY_FLAGS_EN
  logic [1:0] sticky_flags_q, sticky_flags_d;

  // Accumulate flags of delivered results; a set beats a same-cycle clear.
  always_comb begin
    sticky_flags_d = flags_clr ? 2'b00 : sticky_flags_q;
    if (out_valid_q & bus.out_ready) begin
      sticky_flags_d = sticky_flags_d | {out_overflow_q, out_inexact_q};
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags_q <= 2'b00;
    end else begin
      sticky_flags_q <= sticky_flags_d;
    end
  end

  assign sticky_flags = sticky_flags_q;
`endif

endmodule
